// File: rtl/rv32_pkg.sv
// Purpose : shared RV32I constants (bubble word, base opcodes) and the fetch FSM encoding.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   NOP_INSTR      ADDI x0,x0,0, the bubble word shown to decode when nothing is valid
//   OPC_*          7-bit major opcodes, shared with the control/decode stage
//   fetch_state_e  REQ / WAIT / HOLD states of the fetch sequencer
//   fetch_word_t   {instruction, pc} pair carried through the skid and IF/ID stages
//   word_align()   clears the two byte-offset bits of an address
package rv32_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // RV32I major opcodes (instruction[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // REQ : request on the bus, waiting for grant
    // WAIT: one request outstanding, waiting for its read data
    // HOLD: returned word parked in the skid while decode is stalled
    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_word_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Purpose : stallable, flushable IF/ID register holding {valid, instruction, pc} for decode.
// Latency : one cycle from load_i to the outputs.
// Backpressure: stall_i holds a valid entry; accept_o tells the producer when a load is taken.
//
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   flush_i         drop the current entry (highest priority)
//   stall_i         decode cannot take the current entry
//   load_i          write {load_instr_i, load_pc_i}; only asserted while accept_o=1
//   accept_o        register is empty or being consumed this cycle
//   valid_o/instr_o/pc_o  registered entry; instr_o is NOP_INSTR whenever valid_o=0
module if_id_reg #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        load_i,
    input  logic [31:0] load_instr_i,
    input  logic [31:0] load_pc_i,
    output logic        accept_o,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;

    // An empty register may be filled even while decode is stalled: a
    // bubble has nothing to preserve.
    assign accept_o = !r_valid || !stall_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= RESET_PC;
        end else if (flush_i) begin
            // pc is left alone; it is meaningless while valid is low
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (load_i) begin
            r_valid <= 1'b1;
            r_instr <= load_instr_i;
            r_pc    <= load_pc_i;
        end else if (!stall_i) begin
            // entry consumed (or already empty) and nothing new arrives
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end
    end

    assign valid_o = r_valid;
    assign instr_o = r_instr;
    assign pc_o    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Purpose : RV32I fetch stage; owns the PC, issues single-outstanding word reads, feeds IF/ID.
// Latency : gnt -> rvalid (>=1 cycle) -> instr_valid_o on the following edge; 1 instr / 2 cycles.
// Backpressure: stall_i holds IF/ID; a word returning into a stalled IF/ID parks in a skid
//               and no new request is issued until decode drains.
//
// Ports:
//   clk_i, rst_ni                       clock, synchronous active-low reset
//   imem_req_o, imem_addr_o             request valid and word-aligned byte address
//   imem_gnt_i                          request accepted this cycle
//   imem_rvalid_i, imem_rdata_i         read data return, one per grant
//   redirect_i, redirect_pc_i           taken branch / jump from EX; overrides everything
//   stall_i                             decode cannot accept
//   instr_valid_o, instruction_o, pc_o  IF/ID contents towards decode
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        instr_valid_o,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  w_fetch_pc_nxt;
    logic [31:0]  w_fetch_pc_inc;
    logic [31:0]  w_redirect_tgt;
    logic         r_kill;
    logic         w_kill_nxt;
    fetch_word_t  r_skid;
    fetch_word_t  w_skid_nxt;
    logic         w_req;
    logic         w_load;
    fetch_word_t  w_load_word;
    logic         w_accept;

    // modulo 2^32: 0xFFFF_FFFC rolls over to 0
    assign w_fetch_pc_inc = r_fetch_pc + 32'd4;
    assign w_redirect_tgt = word_align(redirect_pc_i);

    // ------------------------------------------------------------------
    // Sequencer. The skid is only meaningful in HOLD, so the state itself
    // serves as its occupancy flag; leaving HOLD by any path empties it.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_kill_nxt     = r_kill;
        w_skid_nxt     = r_skid;
        w_req          = 1'b0;
        w_load         = 1'b0;
        w_load_word    = '{instr: imem_rdata_i, pc: r_fetch_pc};

        case (r_state)
            FETCH_REQ: begin
                w_req = 1'b1;
                if (imem_gnt_i) begin
                    w_state_nxt = FETCH_WAIT;
                    // the granted address is now stale; drop its data
                    if (redirect_i) begin
                        w_kill_nxt = 1'b1;
                    end
                end
            end

            FETCH_WAIT: begin
                if (imem_rvalid_i) begin
                    if (r_kill || redirect_i) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = FETCH_REQ;
                    end else if (w_accept) begin
                        w_load         = 1'b1;
                        w_fetch_pc_nxt = w_fetch_pc_inc;
                        w_state_nxt    = FETCH_REQ;
                    end else begin
                        w_skid_nxt     = '{instr: imem_rdata_i, pc: r_fetch_pc};
                        w_fetch_pc_nxt = w_fetch_pc_inc;
                        w_state_nxt    = FETCH_HOLD;
                    end
                end else if (redirect_i) begin
                    w_kill_nxt = 1'b1;
                end
            end

            FETCH_HOLD: begin
                if (redirect_i) begin
                    w_state_nxt = FETCH_REQ;
                end else if (!stall_i) begin
                    w_load      = 1'b1;
                    w_load_word = r_skid;
                    w_state_nxt = FETCH_REQ;
                end
            end

            default: begin
                w_state_nxt = FETCH_REQ;
            end
        endcase

        // redirect target wins over any increment computed above
        if (redirect_i) begin
            w_fetch_pc_nxt = w_redirect_tgt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= FETCH_REQ;
            r_fetch_pc <= word_align(RESET_PC);
            r_kill     <= 1'b0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_kill     <= w_kill_nxt;
            r_skid     <= w_skid_nxt;
        end
    end

    // no request escapes while reset is held, even combinationally
    assign imem_req_o  = w_req && rst_ni;
    assign imem_addr_o = r_fetch_pc;

    if_id_reg #(
        .RESET_PC  (word_align(RESET_PC)),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (redirect_i),
        .stall_i      (stall_i),
        .load_i       (w_load),
        .load_instr_i (w_load_word.instr),
        .load_pc_i    (w_load_word.pc),
        .accept_o     (w_accept),
        .valid_o      (instr_valid_o),
        .instr_o      (instruction_o),
        .pc_o         (pc_o)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose : self-checking bench for fetch_unit: directed scenarios then randomized traffic.
// Latency : n/a.
// Backpressure: bench drives random stall, grant and read latency.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] rpc;
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pc;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_gnt_i    (gnt),
        .imem_rvalid_i (rvalid),
        .imem_rdata_i  (rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (rpc),
        .stall_i       (stall),
        .instr_valid_o (vld),
        .instruction_o (instr),
        .pc_o          (pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // grant now, return data on the very next cycle
    task automatic fetch_one(input logic [31:0] word);
        gnt = 1'b1;
        tick();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = word;
        tick();
        rvalid = 1'b0;
    endtask

    // instruction memory contents for the random phase: distinct per word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h6B3C_0003;
    endfunction

    // reference state for the random phase
    logic [31:0] exp_pc;
    logic        pend_vld;
    logic [31:0] pend_addr;
    int unsigned pend_cnt;
    logic        p_vld;
    logic [31:0] p_pc;
    logic [31:0] p_instr;
    int          delivered;

    initial begin
        rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        redirect = 1'b0; rpc = '0; stall = 1'b0;

        // ---------------- reset state
        tick(); tick();
        chk("rst_req",   32'(req), 32'd0);
        chk("rst_valid", 32'(vld), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc",    pc, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("first_req",  32'(req), 32'd1);
        chk("first_addr", addr, 32'h0);

        // ---------------- best-case first fetch
        fetch_one(32'h0050_0093);
        chk("t1_valid", 32'(vld), 32'd1);
        chk("t1_instr", instr, 32'h0050_0093);
        chk("t1_pc",    pc, 32'h0);
        chk("t1_addr",  addr, 32'h4);

        // ---------------- stall while second word returns -> skid
        stall = 1'b1;
        gnt   = 1'b1;
        tick();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h00A0_0113;
        tick();
        rvalid = 1'b0;
        chk("skid_hold_instr", instr, 32'h0050_0093);
        chk("skid_hold_pc",    pc, 32'h0);
        chk("skid_no_req",     32'(req), 32'd0);
        tick();
        chk("skid_no_req2",    32'(req), 32'd0);
        stall = 1'b0;
        tick();
        chk("skid_out_valid", 32'(vld), 32'd1);
        chk("skid_out_instr", instr, 32'h00A0_0113);
        chk("skid_out_pc",    pc, 32'h4);
        chk("skid_next_addr", addr, 32'h8);

        // ---------------- redirect while waiting for data
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("bubble_nop", instr, NOP);
        redirect = 1'b1; rpc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("rdw_valid0", 32'(vld), 32'd0);
        tick();
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        rvalid = 1'b0;
        chk("rdw_dropped", 32'(vld), 32'd0);
        chk("rdw_req",     32'(req), 32'd1);
        chk("rdw_addr",    addr, 32'h100);
        fetch_one(32'h0640_0193);
        chk("rdw_instr", instr, 32'h0640_0193);
        chk("rdw_pc",    pc, 32'h100);

        // ---------------- redirect coincident with grant
        gnt = 1'b1; redirect = 1'b1; rpc = 32'h202;
        tick();
        gnt = 1'b0; redirect = 1'b0;
        chk("rdg_valid0", 32'(vld), 32'd0);
        rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
        tick();
        rvalid = 1'b0;
        chk("rdg_dropped", 32'(vld), 32'd0);
        chk("rdg_addr",    addr, 32'h200);
        fetch_one(32'h0000_0297);
        chk("rdg_instr", instr, 32'h0000_0297);
        chk("rdg_pc",    pc, 32'h200);

        // ---------------- misaligned target is forced to a word boundary
        redirect = 1'b1; rpc = 32'h102;
        tick();
        redirect = 1'b0;
        chk("align_addr",  addr, 32'h100);
        chk("align_valid", 32'(vld), 32'd0);

        // ---------------- PC wrap
        redirect = 1'b1; rpc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("wrap_addr0", addr, 32'hFFFF_FFFC);
        fetch_one(32'h0010_0073);
        chk("wrap_pc",    pc, 32'hFFFF_FFFC);
        chk("wrap_addr1", addr, 32'h0);

        // ---------------- reset in the middle of WAIT
        gnt = 1'b1;
        tick();
        gnt   = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(vld), 32'd0);
        chk("mid_rst_instr", instr, NOP);
        chk("mid_rst_pc",    pc, 32'h0);
        chk("mid_rst_req",   32'(req), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_addr", addr, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("req_gated", 32'(req), 32'd0);
        tick();

        // ---------------- randomized traffic against a stream-level model
        rst_n = 1'b1;
        exp_pc = 32'h0; pend_vld = 1'b0; pend_addr = '0; pend_cnt = 0;
        p_vld = 1'b0; p_pc = '0; p_instr = NOP; delivered = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rvalid = 1'b0;
            gnt    = 1'b0;
            if (pend_vld) begin
                if (pend_cnt == 0) begin
                    rvalid   = 1'b1;
                    rdata    = mem_word(pend_addr);
                    pend_vld = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end else if (req && ($urandom_range(0, 99) < 60)) begin
                gnt       = 1'b1;
                pend_vld  = 1'b1;
                pend_addr = addr;
                pend_cnt  = $urandom_range(0, 2);
            end
            stall    = ($urandom_range(0, 99) < 30);
            redirect = ($urandom_range(0, 99) < 6);
            case ($urandom_range(0, 3))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                default: rpc = $urandom_range(0, 255);
            endcase
            tick();

            chk("one_outstanding", 32'(req && pend_vld), 32'd0);
            if (req) chk("addr_align", 32'(addr[1:0]), 32'd0);
            if (redirect) begin
                chk("flush_valid", 32'(vld), 32'd0);
                chk("flush_nop",   instr, NOP);
                exp_pc = rpc & ~32'd3;
            end else if (vld) begin
                if (p_vld && stall) begin
                    chk("hold_pc",    pc, p_pc);
                    chk("hold_instr", instr, p_instr);
                end else begin
                    chk("deliver_pc",    pc, exp_pc);
                    chk("deliver_instr", instr, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    delivered++;
                end
            end else begin
                chk("bubble_instr", instr, NOP);
            end
            p_vld   = vld;
            p_pc    = pc;
            p_instr = instr;
        end
        chk("progress", 32'(delivered >= 150), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
